scroll_controller: RTL and testbench

Sequences the horizontal scroll of the level background by deciding, once per video frame, how many pixels the frame pointer register advances. Sits between player-motion logic and the frame pointer register. Drives that register's ScrollEnable input as a burst of single-cycle pulses; each pulse advances FramePtr by one. Reports the scrolled distance back to player logic so the player sprite can be shifted left, and latches end-of-level when FramePtr reaches the final screen.

---
 rtl/scroll_pkg.sv | 16 +
 rtl/scroll_controller.sv | 104 ++++++++++
 tb/tb_scroll_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared types and default constants for the background scroll sequencer.
package scroll_pkg;

  localparam int                 PTR_W             = 13;
  localparam logic [9:0]         SCROLL_THRESH_DEF = 10'd320;
  localparam int                 MAX_STEP_DEF      = 4;
  localparam logic [PTR_W-1:0]   LEVEL_END_DEF     = 13'd6400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL,
    ST_DONE,
    ST_END
  } scroll_state_t;

endpackage

// File: rtl/scroll_controller.sv
// Once per frame decides how far the background scrolls and issues that many
// single-cycle ScrollEnable pulses to the frame pointer register.
//
// state     | meaning
// ST_IDLE   | waiting for frame_tick; jumps to ST_END once FramePtr hits LEVEL_END
// ST_SCROLL | one ScrollEnable pulse per cycle until the counter runs out
// ST_DONE   | one-cycle ShiftValid report of the burst length
// ST_END    | level finished; LevelEnd held, only reset leaves
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int               PTR_W         = scroll_pkg::PTR_W,
  parameter logic [9:0]       SCROLL_THRESH = SCROLL_THRESH_DEF,
  parameter int               MAX_STEP      = MAX_STEP_DEF,
  parameter logic [PTR_W-1:0] LEVEL_END     = LEVEL_END_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic [9:0]       PlayerX,
  input  logic             PlayerRight,
  input  logic             Pause,
  input  logic             BossLock,
  input  logic [PTR_W-1:0] FramePtr,
  output logic             ScrollEnable,
  output logic [2:0]       PlayerShift,
  output logic             ShiftValid,
  output logic             LevelEnd,
  output logic             Busy
);

  scroll_state_t r_state;
  scroll_state_t w_state_nxt;
  logic [2:0]    r_cnt;
  logic [2:0]    r_latched;
  logic [2:0]    r_shift;
  logic          r_level_end;

  logic [9:0]       w_dx;
  logic [PTR_W-1:0] w_room;
  logic [2:0]       w_steps;
  logic             w_at_end;
  logic             w_start;

  // Differences are only formed when positive, so neither subtraction can wrap.
  always_comb begin
    w_dx     = '0;
    w_room   = '0;
    w_steps  = '0;
    w_at_end = (FramePtr >= LEVEL_END);
    if (PlayerX > SCROLL_THRESH) w_dx = PlayerX - SCROLL_THRESH;
    if (!w_at_end) w_room = LEVEL_END - FramePtr;
    if (PlayerRight && !Pause && !BossLock && (PlayerX > SCROLL_THRESH) && !w_at_end) begin
      w_steps = 3'(MAX_STEP);
      if (w_dx < 10'(MAX_STEP)) w_steps = w_dx[2:0];
      if (w_room < PTR_W'(w_steps)) w_steps = w_room[2:0];
    end
  end

  assign w_start = (r_state == ST_IDLE) && !w_at_end && frame_tick && (w_steps != 3'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_at_end)     w_state_nxt = ST_END;
        else if (w_start) w_state_nxt = ST_SCROLL;
      end
      ST_SCROLL: if (r_cnt == 3'd1) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      ST_END:    w_state_nxt = ST_END;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_latched   <= '0;
      r_shift     <= '0;
      r_level_end <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt     <= w_steps;
        r_latched <= w_steps;
      end
      if (r_state == ST_SCROLL) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) r_shift <= r_latched;
      end
      // Set on the DONE edge so LevelEnd is already up in the first IDLE cycle.
      if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_at_end) r_level_end <= 1'b1;
    end
  end

  assign ScrollEnable = (r_state == ST_SCROLL);
  assign ShiftValid   = (r_state == ST_DONE);
  assign Busy         = (r_state == ST_SCROLL) || (r_state == ST_DONE);
  assign PlayerShift  = r_shift;
  assign LevelEnd     = r_level_end;

endmodule

// File: tb/tb_scroll_controller.sv
// Directed and randomized checks of scroll_controller against a per-cycle
// schedule model of expected pulses and reports.
module tb_scroll_controller;

  localparam int THRESH = 320;
  localparam int MAXS   = 4;
  localparam int LEND   = 6400;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic [9:0]  PlayerX;
  logic        PlayerRight;
  logic        Pause;
  logic        BossLock;
  logic [12:0] FramePtr;
  logic        ScrollEnable;
  logic [2:0]  PlayerShift;
  logic        ShiftValid;
  logic        LevelEnd;
  logic        Busy;

  scroll_controller dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .PlayerX     (PlayerX),
    .PlayerRight (PlayerRight),
    .Pause       (Pause),
    .BossLock    (BossLock),
    .FramePtr    (FramePtr),
    .ScrollEnable(ScrollEnable),
    .PlayerShift (PlayerShift),
    .ShiftValid  (ShiftValid),
    .LevelEnd    (LevelEnd),
    .Busy        (Busy)
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queue of upcoming cycle events; 0 = scroll pulse, k>0 = report of k.
  int q[$];
  int m_shift = 0;
  int m_ptr   = 0;
  bit m_end   = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_steps();
    int s;
    if (!PlayerRight || Pause || BossLock || (int'(PlayerX) <= THRESH)) return 0;
    s = int'(PlayerX) - THRESH;
    if (s > MAXS) s = MAXS;
    if (LEND - m_ptr < s) s = LEND - m_ptr;
    return s;
  endfunction

  task automatic check_outputs();
    bit e_se, e_sv;
    int e_shift;
    e_se    = (q.size() > 0) && (q[0] == 0);
    e_sv    = (q.size() > 0) && (q[0] != 0);
    e_shift = e_sv ? q[0] : m_shift;
    chk("scroll_enable", 16'(ScrollEnable), 16'(e_se));
    chk("shift_valid",   16'(ShiftValid),   16'(e_sv));
    chk("player_shift",  16'(PlayerShift),  16'(e_shift));
    chk("busy",          16'(Busy),         16'(q.size() > 0));
    chk("level_end",     16'(LevelEnd),     16'(m_end));
  endtask

  // Called just after a falling edge with inputs for the coming rising edge set.
  task automatic step();
    int ev;
    bit se_cur;
    check_outputs();
    chk("frame_ptr", 16'(FramePtr), 16'(m_ptr));
    ev = (q.size() > 0) ? q[0] : -1;
    if (ev == 0) m_ptr++;
    if (ev > 0) begin
      m_shift = ev;
      if (m_ptr >= LEND) m_end = 1'b1;
    end
    if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (!m_end) begin
      if (m_ptr >= LEND) m_end = 1'b1;
      else if (frame_tick) begin
        int s;
        s = model_steps();
        for (int i = 0; i < s; i++) q.push_back(0);
        if (s > 0) q.push_back(s);
      end
    end
    se_cur = ScrollEnable;
    @(posedge Clk);
    @(negedge Clk);
    if (se_cur) FramePtr = FramePtr + 13'd1;
    frame_tick = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input int px, input bit rt, input bit ps, input bit bl, input bit tk);
    PlayerX     = 10'(px);
    PlayerRight = rt;
    Pause       = ps;
    BossLock    = bl;
    frame_tick  = tk;
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #1;
    chk("rst_scroll_enable", 16'(ScrollEnable), 16'd0);
    chk("rst_shift_valid",   16'(ShiftValid),   16'd0);
    chk("rst_player_shift",  16'(PlayerShift),  16'd0);
    chk("rst_level_end",     16'(LevelEnd),     16'd0);
    chk("rst_busy",          16'(Busy),         16'd0);
    q.delete();
    m_shift = 0;
    m_end   = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset      = 1'b1;
    frame_tick = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    FramePtr = '0;
    drive(0, 0, 0, 0, 0);
    @(negedge Clk);
    pulse_reset();

    drive(330, 1, 0, 0, 1); run(7);
    drive(322, 1, 0, 0, 1); run(5);
    drive(320, 1, 0, 0, 1); run(3);
    drive(400, 1, 1, 0, 1); run(3);
    drive(400, 1, 0, 1, 1); run(3);

    // Pause and direction change on the 2nd cycle of a 4-step burst
    drive(400, 1, 0, 0, 1); step(); step();
    drive(100, 0, 1, 0, 0); run(6);

    // Second tick while the burst is running
    drive(400, 1, 0, 0, 1); step(); step();
    frame_tick = 1'b1; step();
    run(5);

    // Reset on the 2nd pulse cycle, then a normal burst
    drive(400, 1, 0, 0, 1); step(); step();
    pulse_reset();
    drive(330, 1, 0, 0, 1); run(7);

    repeat (400) begin
      drive($urandom_range(300, 340), $urandom_range(0, 7) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0);
      step();
    end

    drive(400, 1, 0, 0, 0); run(10);
    FramePtr = 13'd6398;
    m_ptr    = 6398;
    drive(400, 1, 0, 0, 1); run(6);
    repeat (20) begin
      drive($urandom_range(321, 400), 1, 0, 0, $urandom_range(0, 1) == 1);
      step();
    end

    pulse_reset();
    drive(400, 1, 0, 0, 1); run(4);

    FramePtr = 13'd6390;
    m_ptr    = 6390;
    pulse_reset();
    drive(330, 1, 0, 0, 1); run(8);
    drive(340, 1, 0, 0, 1); run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
